// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
// Source-domain side of a 4-phase req/ack handshake. One word is held on
// tx_data while tx_req is raised. The destination acknowledges by raising
// tx_ack and later releasing it. tx_ack is asynchronous to clk, so it goes
// through a flop chain before any logic looks at it.
module cdc_handshake_tx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx_req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ack,
    output logic             done,
    output logic [15:0]      xfer_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        ACK_LO = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   tx_req_q;
    logic                   tx_req_d;
    logic [WIDTH-1:0]       tx_data_q;
    logic [WIDTH-1:0]       tx_data_d;
    logic                   done_q;
    logic                   done_d;
    logic [15:0]            xfer_count_q;
    logic [15:0]            xfer_count_d;

    // Synchronizer for tx_ack. Only the last stage is used by the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tx_ack};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // A stale or spurious ack that is still visible blocks new words.
    // Otherwise a new request could be acknowledged by the previous ack.
    assign in_ready = (state_q == IDLE) && !ack_s;

    // Next-state and output logic for the handshake FSM.
    always_comb begin
        state_d      = state_q;
        tx_req_d     = tx_req_q;
        tx_data_d    = tx_data_q;
        done_d       = 1'b0;
        xfer_count_d = xfer_count_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    tx_data_d = in_data;
                    tx_req_d  = 1'b1;
                    state_d   = REQ_HI;
                end else begin
                    state_d   = IDLE;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    state_d  = ACK_LO;
                end else begin
                    tx_req_d = 1'b1;
                end
            end
            ACK_LO: begin
                if (!ack_s) begin
                    state_d      = IDLE;
                    done_d       = 1'b1;
                    xfer_count_d = xfer_count_q + 16'd1;
                end else begin
                    state_d      = ACK_LO;
                end
            end
            default: begin
                state_d  = IDLE;
                tx_req_d = 1'b0;
            end
        endcase
    end

    // State and registered-output update. A reset abandons any transfer
    // in flight without counting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_req_q     <= 1'b0;
            tx_data_q    <= {WIDTH{1'b0}};
            done_q       <= 1'b0;
            xfer_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            tx_req_q     <= tx_req_d;
            tx_data_q    <= tx_data_d;
            done_q       <= done_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign tx_req     = tx_req_q;
    assign tx_data    = tx_data_q;
    assign done       = done_q;
    assign xfer_count = xfer_count_q;

endmodule
